// File: rtl/fifo_rd_ctrl.sv
// Read-side FIFO controller: turns read requests into pops, tracks occupancy and flags.
// Optional sticky underflow flag is built only when FIFO_RD_UNDERFLOW_EN is defined.
module fifo_rd_ctrl #(
  parameter int MEM_SIZE  = 4,
  parameter int WORD_SIZE = 6,
  parameter int PTR       = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fifo_rd,
  input  logic                 push,
  input  logic [PTR-1:0]       empty_threshold,
  input  logic [WORD_SIZE-1:0] mem_data,
  output logic [PTR-1:0]       rd_ptr,
  output logic                 pop,
  output logic [WORD_SIZE-1:0] fifo_data_out,
  output logic                 valid_out,
  output logic                 fifo_empty,
  output logic                 almost_empty,
  output logic                 underflow
);

  typedef enum logic [1:0] {INIT, EMPTY, ACTIVE} state_t;

  localparam logic [PTR:0]   FULL_COUNT = (PTR+1)'(MEM_SIZE);
  localparam logic [PTR:0]   ONE_COUNT  = (PTR+1)'(1);
  localparam logic [PTR-1:0] LAST_PTR   = PTR'(MEM_SIZE - 1);
  localparam logic [PTR-1:0] ONE_PTR    = PTR'(1);

  state_t         state, state_next;
  logic [PTR:0]   count, count_next;
  logic           push_eff;

  // A push into a full memory is dropped so count never exceeds MEM_SIZE.
  always_comb begin
    push_eff   = push && (count < FULL_COUNT);
    pop        = fifo_rd && (state == ACTIVE);
    count_next = count;
    case ({push_eff, pop})
      2'b10:   count_next = count + ONE_COUNT;
      2'b01:   count_next = count - ONE_COUNT;
      default: count_next = count;
    endcase

    state_next = state;
    case (state)
      INIT:    state_next = (count_next == '0) ? EMPTY : ACTIVE;
      EMPTY:   if (push_eff) state_next = ACTIVE;
      ACTIVE:  if (count_next == '0) state_next = EMPTY;
      default: state_next = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= INIT;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr        <= '0;
      fifo_data_out <= '0;
      valid_out     <= 1'b0;
    end else begin
      valid_out <= pop;
      if (pop) begin
        fifo_data_out <= mem_data;
        rd_ptr        <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + ONE_PTR;
      end
    end
  end

  // Flags come from the registered count only, so they cannot glitch.
  assign fifo_empty   = (count == '0);
  assign almost_empty = (count != '0) && (count <= {1'b0, empty_threshold});

`ifdef FIFO_RD_UNDERFLOW_EN
  logic underflow_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      underflow_q <= 1'b0;
    end else if (fifo_rd && (state == EMPTY)) begin
      underflow_q <= 1'b1;
    end
  end

  assign underflow = underflow_q;
`else
  assign underflow = 1'b0;
`endif

endmodule

// File: doc/fifo_rd_ctrl.md
# fifo_rd_ctrl

Read-side controller for the parameterised FIFO: the pop-side counterpart of the write controller that drives `wr_ptr` and `push`. It accepts `fifo_rd` requests, generates `pop` and `rd_ptr` into the shared memory, and registers the read word onto `fifo_data_out` with a valid strobe. It tracks occupancy from the write side's `push` and its own `pop`, and produces `fifo_empty` and `almost_empty`.

## Interface
Parameters:
- `MEM_SIZE`, 4, number of memory entries; must satisfy `MEM_SIZE <= 2^PTR`.
- `WORD_SIZE`, 6, bits per word.
- `PTR`, 3, pointer width.

Ports:
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `fifo_rd`  in  1  read request from the consumer.
- `push`  in  1  write strobe from the write controller; one word is written this cycle.
- `empty_threshold`  in  PTR  almost-empty level.
- `mem_data`  in  WORD_SIZE  memory word at `rd_ptr`, combinational read.
- `rd_ptr`  out  PTR  read address.
- `pop`  out  1  read accepted this cycle.
- `fifo_data_out`  out  WORD_SIZE  registered read data.
- `valid_out`  out  1  `fifo_data_out` was updated by the last edge.
- `fifo_empty`  out  1  occupancy is 0.
- `almost_empty`  out  1  `0 < occupancy <= empty_threshold`.
- `underflow`  out  1  sticky read-while-empty error (see Configuration).

## Operation
- Internal state:
  - `count`: PTR+1 bits, range 0..MEM_SIZE.
  - `state`: one of INIT, EMPTY, ACTIVE.
- FSM:
  - INIT: entered on reset; lasts exactly one cycle after `reset` falls. `pop` is forced to 0 and `push` is still counted. Goes to EMPTY if `count == 0`, else ACTIVE.
  - EMPTY: `count == 0`. Goes to ACTIVE on the edge where `push` = 1.
  - ACTIVE: `count > 0`. Goes to EMPTY when the next count is 0.
- `pop` is combinational: `fifo_rd && state == ACTIVE`. No pop is generated in INIT or EMPTY.
- On an edge with `pop` = 1:
  - `fifo_data_out <= mem_data`.
  - `valid_out <= 1`.
  - `rd_ptr` increments; it wraps from MEM_SIZE-1 to 0.
- On an edge with `pop` = 0: `valid_out <= 0`; `fifo_data_out` and `rd_ptr` hold.
- Occupancy update: `count_next = count + push_eff - pop`, where `push_eff = push && (count < MEM_SIZE)`. A push while `count == MEM_SIZE` is ignored.
- Push and pop in the same cycle: count is unchanged, and the pointer and data still advance.
- Push while empty: no pop can occur that cycle. Count becomes 1 and the new word is poppable from the next cycle.
- `fifo_empty` and `almost_empty` are decoded from the registered `count` only, so they are glitch-free.
- `empty_threshold = 0` keeps `almost_empty` permanently 0.

## Timing
- Reset values: `rd_ptr` = 0, `pop` = 0, `fifo_data_out` = 0, `valid_out` = 0, `fifo_empty` = 1, `almost_empty` = 0, `underflow` = 0, `count` = 0, state INIT.
- Reset is asynchronous and takes effect mid-operation. Any in-flight read is discarded, and outputs return to reset values within the same cycle.
- Read latency: a request in cycle N with `pop` = 1 gives data and `valid_out` = 1 in cycle N+1. Back-to-back requests give one word per cycle.
- Push-to-read latency: a push at edge N clears `fifo_empty` after edge N. The earliest `pop` is in cycle N+1, and the data arrives in cycle N+2.
- `fifo_empty` and `almost_empty` update one edge after the push or pop that changes `count`.

## Configuration
- `FIFO_RD_UNDERFLOW_EN` defined: `underflow` is set at the edge where `fifo_rd` = 1 and `pop` = 0 while in state EMPTY. It stays set until `reset`. Requests during INIT do not set it.
- Not defined: `underflow` is tied to 0 and no flag register is built. All other behaviour is identical.

## Test plan
- Reset, then idle 3 cycles -> `fifo_empty` = 1, `rd_ptr` = 0, `valid_out` = 0, `pop` = 0 throughout INIT.
- Push 3 words (0x11, 0x22, 0x33), then `fifo_rd` held for 4 cycles -> `pop` = 1 for 3 cycles. `fifo_data_out` = 0x11, 0x22, 0x33 each with `valid_out` = 1. Then `fifo_empty` = 1 and the 4th request gives `pop` = 0.
- MEM_SIZE = 4, 6 full write/read cycles -> `rd_ptr` sequence 0,1,2,3,0,1,… and data order preserved across the wrap.
- `empty_threshold` = 2 with pushes to 4 then pops to 0 -> `almost_empty` = 1 only at counts 2 and 1, and `fifo_empty` = 1 only at 0.
- Count = 2, then `push` and `fifo_rd` together for 5 cycles -> count stays 2, 5 words are delivered, and `fifo_empty` never asserts.
- With `FIFO_RD_UNDERFLOW_EN`: `fifo_rd` = 1 while empty -> `underflow` = 1 next cycle and stays set after later pushes and pops until `reset`. Without the macro, `underflow` stays 0.
